// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the alu_ctrl block: command op encodings and the
// controller FSM state type.
// Optional feature macro used by the block: ALU_CTRL_CARRY_EN (adds rsp_carry).
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_ADD = 2'b01,
        OP_SLL = 2'b10,
        OP_SLT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage : alu_ctrl_pkg

// File: rtl/alu_ctrl_core.sv
// ---------------------------------------------------------------------------
// alu_ctrl_core
// Purely combinational single-cycle datapath for AND, ADD (wrapping) and
// unsigned SLT. SLL is iterative and lives in the controller, so this core
// returns 0 for it.
// Macro ALU_CTRL_CARRY_EN: when defined, o_carry carries the ADD carry-out.
//
// Ports:
//   i_op      operation (op_e)
//   i_x, i_y  operands
//   o_result  combinational result
//   o_carry   ADD carry-out, 0 for other ops (ALU_CTRL_CARRY_EN only)
// ---------------------------------------------------------------------------
module alu_ctrl_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_result
`ifdef ALU_CTRL_CARRY_EN
    ,
    output logic             o_carry
`endif
);

`ifdef ALU_CTRL_CARRY_EN
    // One extra bit so the carry-out falls out of the same adder.
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, i_x} + {1'b0, i_y};
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        o_result = '0;
`ifdef ALU_CTRL_CARRY_EN
        o_carry  = 1'b0;
`endif
        case (i_op)
            OP_AND: o_result = i_x & i_y;
`ifdef ALU_CTRL_CARRY_EN
            OP_ADD: {o_carry, o_result} = w_sum;
`else
            OP_ADD: o_result = i_x + i_y;
`endif
            OP_SLT: o_result = WIDTH'(i_x < i_y);
            default: o_result = '0;
        endcase
    end

endmodule : alu_ctrl_core

// File: rtl/alu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_ctrl
// Command/response ALU controller. A command is accepted in IDLE, executed
// in EXEC (one cycle for AND/ADD/SLT, shamt+1 cycles for the iterative SLL)
// and held in RESP until the consumer takes it. The last result stays on
// rsp_result/rsp_zero until the next one is registered.
// Macro ALU_CTRL_CARRY_EN: when defined, adds the registered rsp_carry output.
//
// Ports:
//   clock, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op/x/y/shamt        command fields, captured on accept
//   rsp_valid/rsp_ready     response handshake
//   rsp_result, rsp_zero    registered result and its zero flag
//   rsp_carry               registered ADD carry (ALU_CTRL_CARRY_EN only)
//   busy                    high in any state other than IDLE
// ---------------------------------------------------------------------------
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHIFT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic [SHIFT-1:0] cmd_shamt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy
`ifdef ALU_CTRL_CARRY_EN
    ,
    output logic             rsp_carry
`endif
);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;      // also the SLL working register
    logic [SHIFT-1:0] r_cnt;    // remaining SLL shift steps
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] w_core_result;
`ifdef ALU_CTRL_CARRY_EN
    logic             r_carry;
    logic             w_core_carry;
`endif

    alu_ctrl_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .i_op     (r_op),
        .i_x      (r_x),
        .i_y      (r_y),
        .o_result (w_core_result)
`ifdef ALU_CTRL_CARRY_EN
        ,
        .o_carry  (w_core_carry)
`endif
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_AND;
            r_x      <= '0;
            r_y      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
`ifdef ALU_CTRL_CARRY_EN
            r_carry  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= op_e'(cmd_op);
                        r_x     <= cmd_x;
                        r_y     <= cmd_y;
                        r_cnt   <= cmd_shamt;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_op == OP_SLL) begin
                        // One bit per cycle; finish once the count is spent.
                        if (r_cnt != '0) begin
                            r_y   <= r_y << 1;
                            r_cnt <= r_cnt - SHIFT'(1);
                        end else begin
                            r_result <= r_y;
                            r_zero   <= (r_y == '0);
`ifdef ALU_CTRL_CARRY_EN
                            r_carry  <= 1'b0;
`endif
                            r_state  <= ST_RESP;
                        end
                    end else begin
                        r_result <= w_core_result;
                        r_zero   <= (w_core_result == '0);
`ifdef ALU_CTRL_CARRY_EN
                        r_carry  <= w_core_carry;
`endif
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
`ifdef ALU_CTRL_CARRY_EN
    assign rsp_carry  = r_carry;
`endif

endmodule : alu_ctrl

// File: tb/tb_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl
// Self-checking bench for alu_ctrl (WIDTH=4, SHIFT=2). The driver pushes the
// expected response of every accepted command into a queue; an independent
// monitor pops and compares when a response appears, checking value,
// zero flag, carry (when ALU_CTRL_CARRY_EN is defined) and latency.
// ---------------------------------------------------------------------------
module tb_alu_ctrl;

    localparam int W = 4;
    localparam int S = 2;

    typedef struct {
        int result;
        int zero;
        int carry;
        int lat;
        int acc_edge;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = '0;
    logic [W-1:0] cmd_x = '0;
    logic [W-1:0] cmd_y = '0;
    logic [S-1:0] cmd_shamt = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic         busy;
`ifdef ALU_CTRL_CARRY_EN
    logic         rsp_carry;
`endif

    alu_ctrl #(.WIDTH(W), .SHIFT(S)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_shamt  (cmd_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
`ifdef ALU_CTRL_CARRY_EN
        ,
        .rsp_carry  (rsp_carry)
`endif
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_err    = 0;
    int   edge_cnt = 0;
    exp_t exp_q[$];
    bit   in_resp  = 1'b0;
    bit   rand_rr  = 1'b0;

    initial forever begin
        @(posedge clock);
        edge_cnt++;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: straight arithmetic on integers from the op rules.
    function automatic exp_t model(input int op, input int x, input int y, input int sh);
        exp_t e;
        int   m;
        m = 1 << W;
        e.carry = 0;
        e.lat   = 1;
        case (op)
            0: e.result = x & y;
            1: begin
                e.result = (x + y) % m;
                e.carry  = ((x + y) >= m) ? 1 : 0;
            end
            2: begin
                e.result = (y * (1 << sh)) % m;
                e.lat    = sh + 1;
            end
            default: e.result = (x < y) ? 1 : 0;
        endcase
        e.zero     = (e.result == 0) ? 1 : 0;
        e.acc_edge = 0;
        return e;
    endfunction

    // Monitor: samples on the falling edge, where all inputs and outputs are settled.
    initial begin
        exp_t cur;
        bit   have_cur;
        have_cur = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                have_cur = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_rsp: got result %0d required no response", rsp_result);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("rsp_latency", edge_cnt - cur.acc_edge, cur.lat);
                    end
                    in_resp = 1'b1;
                end
                if (have_cur) begin
                    check("rsp_result", int'(rsp_result), cur.result);
                    check("rsp_zero", int'(rsp_zero), cur.zero);
`ifdef ALU_CTRL_CARRY_EN
                    check("rsp_carry", int'(rsp_carry), cur.carry);
`endif
                    check("resp_cmd_ready", int'(cmd_ready), 0);
                end
                if (rsp_ready) in_resp = 1'b0;
            end
        end
    end

    // Offer a command until accepted; scramble the fields right after accept.
    task automatic send(input int op, input int x, input int y, input int sh);
        exp_t e;
        e = model(op, x, y, sh);
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            cmd_valid = 1'b1;
            cmd_op    = 2'(op);
            cmd_x     = W'(x);
            cmd_y     = W'(y);
            cmd_shamt = S'(sh);
            if (cmd_ready) begin
                e.acc_edge = edge_cnt + 1;
                exp_q.push_back(e);
                @(posedge clock); #1;
                cmd_valid = 1'b0;
                cmd_op    = 2'($urandom);
                cmd_x     = W'($urandom);
                cmd_y     = W'($urandom);
                cmd_shamt = S'($urandom);
                return;
            end
        end
        cmd_valid = 1'b0;
        n_checks++;
        n_err++;
        $display("FAIL accept_timeout: got cmd_ready 0 required 1 within 100 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            rsp_ready = rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (exp_q.size() == 0 && !in_resp && cmd_ready) return;
        end
        n_checks++;
        n_err++;
        $display("FAIL idle_timeout: got busy %0d required 0 within 200 cycles", busy);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   dir [7][4] = '{'{1, 9, 8, 0}, '{1, 15, 1, 0}, '{2, 0, 3, 3}, '{2, 0, 3, 0},
                            '{3, 2, 5, 0}, '{3, 3, 3, 0}, '{0, 12, 6, 0}};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_result", int'(rsp_result), 0);
        check("rst_zero", int'(rsp_zero), 1);
        reset = 1'b0;

        // Directed cases
        foreach (dir[i]) begin
            send(dir[i][0], dir[i][1], dir[i][2], dir[i][3]);
            wait_idle();
        end

        // Retention in IDLE of the last result (AND 12 & 6 = 4)
        repeat (3) @(posedge clock);
        #1;
        e = model(0, 12, 6, 0);
        check("retain_result", int'(rsp_result), e.result);
        check("retain_zero", int'(rsp_zero), e.zero);

        // Randomized commands with random backpressure
        rand_rr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 3));
            wait_idle();
        end
        rand_rr = 1'b0;

        // Backpressure: hold rsp_ready low while new commands are offered
        rsp_ready = 1'b0;
        send(1, 15, 1, 0);
        for (int i = 0; i < 10 && !rsp_valid; i++) begin
            @(posedge clock); #1;
        end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_op    = 2'($urandom);
            cmd_x     = W'($urandom);
            cmd_y     = W'($urandom);
            cmd_shamt = S'($urandom);
            check("bp_rsp_valid", int'(rsp_valid), 1);
            check("bp_cmd_ready", int'(cmd_ready), 0);
            @(posedge clock); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        e = model(1, 15, 1, 0);
        check("bp_idle_cmd_ready", int'(cmd_ready), 1);
        check("bp_idle_rsp_valid", int'(rsp_valid), 0);
        check("bp_idle_result", int'(rsp_result), e.result);
        check("bp_idle_zero", int'(rsp_zero), e.zero);
        repeat (8) @(posedge clock);
        #1;
        check("bp_no_extra", exp_q.size() + int'(in_resp) + int'(busy), 0);

        // Reset during the 2nd EXEC cycle of SLL shamt=3
        send(2, 0, 3, 3);
        @(posedge clock); #1;
        check("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        exp_q.delete();
        in_resp = 1'b0;
        #1;
        check("mid_rst_rsp_valid", int'(rsp_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cmd_ready", int'(cmd_ready), 1);
        check("mid_rst_result", int'(rsp_result), 0);
        check("mid_rst_zero", int'(rsp_zero), 1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("post_rst_no_rsp", int'(rsp_valid), 0);
        check("post_rst_result", int'(rsp_result), 0);

        // First command after reset is processed normally
        send(3, 2, 5, 0);
        wait_idle();
        send(2, 0, 9, 2);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_alu_ctrl
